// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
//  Module  : hazard_ctrl_pkg
//  Brief   : Shared FSM state encoding, forward selects and control bundles
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_LDSTALL = 3'd1;
    localparam logic [2:0] ST_MEMWAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int              STALL_W    = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [1:0]      DRAIN_LAST = 2'd1;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic freeze;
        logic exmem_en;
        logic bubble;
        logic flush;
    } ctrl_t;

    // HOLD_FRONT: freeze PC/IF-ID while a bubble is clocked into ID/EX
    localparam ctrl_t CTRL_RUN        = 6'b111100;
    localparam ctrl_t CTRL_FLUSH      = 6'b111111;
    localparam ctrl_t CTRL_HOLD_FRONT = 6'b001110;
    localparam ctrl_t CTRL_FROZEN     = 6'b000000;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
// ============================================================================
//  Module  : fwd_unit
//  Brief   : Operand forward select for one ALU source (EX/MEM beats MEM/WB)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [2:0] rs,
    input  logic       use_rs,
    input  logic [2:0] wr_exmem,
    input  logic       regwrite_exmem,
    input  logic       load_exmem,
    input  logic [2:0] wr_memwb,
    input  logic       regwrite_memwb,
    output logic [1:0] fwd
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    // A load in EX/MEM has no ALU result yet, so it can only be picked up from WB
    assign w_hit_exmem = regwrite_exmem && use_rs && (wr_exmem == rs) && !load_exmem;
    assign w_hit_memwb = regwrite_memwb && use_rs && (wr_memwb == rs);

    always_comb begin
        fwd = FWD_RF;
        if (w_hit_exmem)
            fwd = FWD_EXMEM;
        else if (w_hit_memwb)
            fwd = FWD_WB;
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module  : hazard_ctrl
//  Brief   : Pipeline hazard control: forwarding, stalls, flush, halt drain
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         Rs1_IFID,
    input  logic [2:0]         Rs2_IFID,
    input  logic               UseRs1_IFID,
    input  logic               UseRs2_IFID,
    input  logic [2:0]         Rs1_IDEX,
    input  logic [2:0]         Rs2_IDEX,
    input  logic               UseRs1_IDEX,
    input  logic               UseRs2_IDEX,
    input  logic [2:0]         WrR_IDEX,
    input  logic [2:0]         WrR_EXMEM,
    input  logic [2:0]         WrR_MEMWB,
    input  logic               RegWrite_IDEX,
    input  logic               RegWrite_EXMEM,
    input  logic               RegWrite_MEMWB,
    input  logic               MemRead_IDEX,
    input  logic               loadDetect_EXMEM,
    input  logic               takeBranch,
    input  logic               halt_EXMEM,
    input  logic               mem_busy,
    output logic [1:0]         forwardA,
    output logic [1:0]         forwardB,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               freeze,
    output logic               exmem_en,
    output logic               bubble_IDEX,
    output logic               flush_IFID,
    output logic               halted,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_drain_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_halted;
    logic               w_ldu;
    ctrl_t              w_ctrl;

    fwd_unit u_fwd_a (
        .rs             (Rs1_IDEX),
        .use_rs         (UseRs1_IDEX),
        .wr_exmem       (WrR_EXMEM),
        .regwrite_exmem (RegWrite_EXMEM),
        .load_exmem     (loadDetect_EXMEM),
        .wr_memwb       (WrR_MEMWB),
        .regwrite_memwb (RegWrite_MEMWB),
        .fwd            (forwardA)
    );

    fwd_unit u_fwd_b (
        .rs             (Rs2_IDEX),
        .use_rs         (UseRs2_IDEX),
        .wr_exmem       (WrR_EXMEM),
        .regwrite_exmem (RegWrite_EXMEM),
        .load_exmem     (loadDetect_EXMEM),
        .wr_memwb       (WrR_MEMWB),
        .regwrite_memwb (RegWrite_MEMWB),
        .fwd            (forwardB)
    );

    assign w_ldu = MemRead_IDEX && RegWrite_IDEX &&
                   ((UseRs1_IFID && (WrR_IDEX == Rs1_IFID)) ||
                    (UseRs2_IFID && (WrR_IDEX == Rs2_IFID)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_RUN;
        else
            r_state <= w_next_state;
    end

    // MEMWAIT with memory ready is a normal RUN cycle: the branch or hazard that
    // sat frozen in the pipe during the wait must still be acted on now.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN, ST_MEMWAIT: begin
                if (mem_busy)
                    w_next_state = ST_MEMWAIT;
                else if (halt_EXMEM)
                    w_next_state = ST_DRAIN;
                else if (takeBranch)
                    w_next_state = ST_RUN;
                else if (w_ldu)
                    w_next_state = ST_LDSTALL;
                else
                    w_next_state = ST_RUN;
            end
            ST_LDSTALL: w_next_state = mem_busy ? ST_MEMWAIT : ST_RUN;
            ST_DRAIN: begin
                if (!mem_busy && (r_drain_cnt == DRAIN_LAST))
                    w_next_state = ST_HALTED;
            end
            ST_HALTED: w_next_state = ST_HALTED;
            default:   w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        w_ctrl = CTRL_RUN;
        case (r_state)
            ST_RUN, ST_MEMWAIT: begin
                if (mem_busy)
                    w_ctrl = CTRL_FROZEN;
                else if (halt_EXMEM)
                    w_ctrl = CTRL_HOLD_FRONT;
                else if (takeBranch)
                    w_ctrl = CTRL_FLUSH;
                else if (w_ldu)
                    w_ctrl = CTRL_HOLD_FRONT;
            end
            ST_LDSTALL: begin
                if (mem_busy)
                    w_ctrl = CTRL_FROZEN;
            end
            ST_DRAIN:  w_ctrl = mem_busy ? CTRL_FROZEN : CTRL_HOLD_FRONT;
            ST_HALTED: w_ctrl = CTRL_FROZEN;
            default:   w_ctrl = CTRL_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drain_cnt <= 2'd0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            if (r_state != ST_DRAIN)
                r_drain_cnt <= 2'd0;
            else if (!mem_busy)
                r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? 2'd0 : r_drain_cnt + 2'd1;

            if ((r_state != ST_HALTED) && !w_ctrl.pc_en && (r_stall_cnt != STALL_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;

            r_halted <= (w_next_state == ST_HALTED);
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign freeze      = w_ctrl.freeze;
    assign exmem_en    = w_ctrl.exmem_en;
    assign bubble_IDEX = w_ctrl.bubble;
    assign flush_IFID  = w_ctrl.flush;
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module  : tb_hazard_ctrl
//  Brief   : Self-checking bench for hazard_ctrl (vectors, sequences, random)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  Rs1_IFID, Rs2_IFID, Rs1_IDEX, Rs2_IDEX, WrR_IDEX, WrR_EXMEM, WrR_MEMWB;
    logic        UseRs1_IFID, UseRs2_IFID, UseRs1_IDEX, UseRs2_IDEX;
    logic        RegWrite_IDEX, RegWrite_EXMEM, RegWrite_MEMWB, MemRead_IDEX, loadDetect_EXMEM;
    logic        takeBranch, halt_EXMEM, mem_busy;
    logic [1:0]  forwardA, forwardB;
    logic        pc_en, ifid_en, freeze, exmem_en, bubble_IDEX, flush_IFID, halted;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .Rs1_IFID(Rs1_IFID), .Rs2_IFID(Rs2_IFID), .UseRs1_IFID(UseRs1_IFID), .UseRs2_IFID(UseRs2_IFID),
        .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX), .UseRs1_IDEX(UseRs1_IDEX), .UseRs2_IDEX(UseRs2_IDEX),
        .WrR_IDEX(WrR_IDEX), .WrR_EXMEM(WrR_EXMEM), .WrR_MEMWB(WrR_MEMWB),
        .RegWrite_IDEX(RegWrite_IDEX), .RegWrite_EXMEM(RegWrite_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB),
        .MemRead_IDEX(MemRead_IDEX), .loadDetect_EXMEM(loadDetect_EXMEM),
        .takeBranch(takeBranch), .halt_EXMEM(halt_EXMEM), .mem_busy(mem_busy),
        .forwardA(forwardA), .forwardB(forwardB),
        .pc_en(pc_en), .ifid_en(ifid_en), .freeze(freeze), .exmem_en(exmem_en),
        .bubble_IDEX(bubble_IDEX), .flush_IFID(flush_IFID),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic idle();
        {Rs1_IFID, Rs2_IFID, Rs1_IDEX, Rs2_IDEX, WrR_IDEX, WrR_EXMEM, WrR_MEMWB} = '0;
        {UseRs1_IFID, UseRs2_IFID, UseRs1_IDEX, UseRs2_IDEX} = '0;
        {RegWrite_IDEX, RegWrite_EXMEM, RegWrite_MEMWB, MemRead_IDEX, loadDetect_EXMEM} = '0;
        {takeBranch, halt_EXMEM, mem_busy} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: pending drain cycles, a one-shot post-load-stall slot and a halt flag
    bit m_halted, m_ldstall;
    int m_drain_left, m_cnt;
    bit e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl;
    bit n_halted, n_ldstall;
    int n_drain, n_cnt;

    function automatic logic [1:0] fwd_model(input logic [2:0] rs, input logic use_rs);
        if (RegWrite_EXMEM && use_rs && WrR_EXMEM == rs && !loadDetect_EXMEM) return 2'b10;
        if (RegWrite_MEMWB && use_rs && WrR_MEMWB == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_eval();
        bit ldu;
        ldu = MemRead_IDEX && RegWrite_IDEX &&
              ((UseRs1_IFID && WrR_IDEX == Rs1_IFID) || (UseRs2_IFID && WrR_IDEX == Rs2_IFID));
        {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b111100;
        n_halted = m_halted; n_ldstall = 0; n_drain = m_drain_left;
        if (m_halted)
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b000000;
        else if (mem_busy)
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b000000;
        else if (m_drain_left > 0) begin
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b001110;
            n_drain = m_drain_left - 1;
            if (n_drain == 0) n_halted = 1;
        end else if (m_ldstall) begin
            // one normal cycle after the load-use bubble
        end else if (halt_EXMEM) begin
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b001110;
            n_drain = 2;
        end else if (takeBranch)
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b111111;
        else if (ldu) begin
            {e_pc, e_ifid, e_frz, e_exm, e_bub, e_fl} = 6'b001110;
            n_ldstall = 1;
        end
        n_cnt = (!m_halted && !e_pc && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    endfunction

    task automatic run_cycle(input string tag);
        #1;
        model_eval();
        check($sformatf("%s.pc_en", tag),    pc_en,       e_pc);
        check($sformatf("%s.ifid_en", tag),  ifid_en,     e_ifid);
        check($sformatf("%s.freeze", tag),   freeze,      e_frz);
        check($sformatf("%s.exmem_en", tag), exmem_en,    e_exm);
        check($sformatf("%s.bubble", tag),   bubble_IDEX, e_bub);
        check($sformatf("%s.flush", tag),    flush_IFID,  e_fl);
        check($sformatf("%s.halted", tag),   halted,      m_halted);
        check($sformatf("%s.stall_cnt", tag), stall_cnt,  m_cnt);
        check($sformatf("%s.fwdA", tag),     forwardA,    fwd_model(Rs1_IDEX, UseRs1_IDEX));
        check($sformatf("%s.fwdB", tag),     forwardB,    fwd_model(Rs2_IDEX, UseRs2_IDEX));
        @(posedge clk);
        m_halted = n_halted; m_ldstall = n_ldstall; m_drain_left = n_drain; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        #2;
        check("rst.stall_cnt", stall_cnt, 0);
        check("rst.halted", halted, 0);
        check("rst.pc_en", pc_en, 1);
        m_halted = 0; m_ldstall = 0; m_drain_left = 0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [2:0] rs1, rs2;
        logic       u1, u2;
        logic [2:0] wex, wwb;
        logic       rwex, rwwb, ld;
        logic [1:0] ea, eb;
    } fwd_vec_t;

    fwd_vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, FWD_EXMEM, FWD_RF};
        vecs[1] = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, FWD_WB,    FWD_RF};
        vecs[2] = '{3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, FWD_WB,    FWD_WB};
        vecs[3] = '{3'd2, 3'd4, 1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 1'b1, 1'b0, FWD_EXMEM, FWD_WB};
        vecs[4] = '{3'd6, 3'd6, 1'b0, 1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0, FWD_RF,    FWD_EXMEM};
        vecs[5] = '{3'd1, 3'd7, 1'b1, 1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, FWD_RF,    FWD_RF};
        vecs[6] = '{3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, FWD_RF,    FWD_RF};
        vecs[7] = '{3'd5, 3'd5, 1'b1, 1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 1'b1, FWD_RF,    FWD_RF};

        idle();
        rst = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            idle();
            Rs1_IDEX = vecs[i].rs1; Rs2_IDEX = vecs[i].rs2;
            UseRs1_IDEX = vecs[i].u1; UseRs2_IDEX = vecs[i].u2;
            WrR_EXMEM = vecs[i].wex; WrR_MEMWB = vecs[i].wwb;
            RegWrite_EXMEM = vecs[i].rwex; RegWrite_MEMWB = vecs[i].rwwb;
            loadDetect_EXMEM = vecs[i].ld;
            #1;
            check($sformatf("fwd%0d.A", i), forwardA, vecs[i].ea);
            check($sformatf("fwd%0d.B", i), forwardB, vecs[i].eb);
            tick();
        end

        // Load-use on Rs2: one stall cycle
        idle();
        MemRead_IDEX = 1; RegWrite_IDEX = 1; WrR_IDEX = 3'd5; Rs2_IFID = 3'd5; UseRs2_IFID = 1;
        #1;
        check("ldu.pc_en", pc_en, 0);
        check("ldu.bubble", bubble_IDEX, 1);
        check("ldu.freeze", freeze, 1);
        check("ldu.cnt0", stall_cnt, 0);
        tick();
        idle();
        #1;
        check("ldu_after.pc_en", pc_en, 1);
        check("ldu_after.bubble", bubble_IDEX, 0);
        check("ldu_after.cnt1", stall_cnt, 1);
        tick();

        // Branch wins over load-use
        MemRead_IDEX = 1; RegWrite_IDEX = 1; WrR_IDEX = 3'd5; Rs2_IFID = 3'd5; UseRs2_IFID = 1;
        takeBranch = 1;
        #1;
        check("br_ldu.flush", flush_IFID, 1);
        check("br_ldu.pc_en", pc_en, 1);
        check("br_ldu.bubble", bubble_IDEX, 1);
        tick();
        idle();
        #1;
        check("br_ldu.flush_done", flush_IFID, 0);
        check("br_ldu.pc_en_next", pc_en, 1);
        check("br_ldu.cnt", stall_cnt, 1);
        tick();

        // mem_busy for three cycles
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("busy%0d.enables", i), {pc_en, ifid_en, freeze, exmem_en}, 4'b0000);
            tick();
        end
        mem_busy = 0;
        #1;
        check("busy_end.pc_en", pc_en, 1);
        check("busy_end.cnt", stall_cnt, 3);
        tick();
        #1;
        check("busy_run.enables", {pc_en, ifid_en, freeze, exmem_en}, 4'b1111);
        check("busy_run.cnt", stall_cnt, 3);
        tick();

        // Halt drain then reset out of HALTED
        do_reset();
        halt_EXMEM = 1;
        #1;
        check("halt0.exmem_en", exmem_en, 1);
        check("halt0.pc_en", pc_en, 0);
        check("halt0.bubble", bubble_IDEX, 1);
        tick();
        halt_EXMEM = 0;
        for (int i = 1; i < 3; i++) begin
            #1;
            check($sformatf("drain%0d.exmem_en", i), exmem_en, 1);
            check($sformatf("drain%0d.pc_en", i), pc_en, 0);
            check($sformatf("drain%0d.halted", i), halted, 0);
            tick();
        end
        #1;
        check("halted.flag", halted, 1);
        check("halted.enables", {pc_en, ifid_en, freeze, exmem_en}, 4'b0000);
        check("halted.cnt", stall_cnt, 3);
        tick();
        #1;
        check("halted.cnt_hold", stall_cnt, 3);
        do_reset();
        #1;
        check("post_halt.halted", halted, 0);
        check("post_halt.pc_en", pc_en, 1);
        tick();

        // Reset in the middle of a drain
        halt_EXMEM = 1;
        tick();
        do_reset();
        #1;
        check("mid_drain.pc_en", pc_en, 1);
        check("mid_drain.exmem_en", exmem_en, 1);
        tick();

        // Long mem_busy drives the counter into saturation
        do_reset();
        mem_busy = 1;
        repeat (65534) tick();
        #1;
        check("sat.below", stall_cnt, 16'hFFFE);
        tick();
        #1;
        check("sat.reach", stall_cnt, 16'hFFFF);
        repeat (3) tick();
        #1;
        check("sat.hold", stall_cnt, 16'hFFFF);
        tick();

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            Rs1_IFID = 3'($urandom_range(0, 3)); Rs2_IFID = 3'($urandom_range(0, 3));
            Rs1_IDEX = 3'($urandom_range(0, 3)); Rs2_IDEX = 3'($urandom_range(0, 3));
            WrR_IDEX = 3'($urandom_range(0, 3)); WrR_EXMEM = 3'($urandom_range(0, 3));
            WrR_MEMWB = 3'($urandom_range(0, 3));
            UseRs1_IFID = 1'($urandom); UseRs2_IFID = 1'($urandom);
            UseRs1_IDEX = 1'($urandom); UseRs2_IDEX = 1'($urandom);
            RegWrite_IDEX = 1'($urandom); RegWrite_EXMEM = 1'($urandom); RegWrite_MEMWB = 1'($urandom);
            MemRead_IDEX = ($urandom % 3 == 0); loadDetect_EXMEM = ($urandom % 3 == 0);
            takeBranch = ($urandom % 5 == 0); halt_EXMEM = ($urandom % 80 == 0);
            mem_busy = ($urandom % 6 == 0);
            run_cycle($sformatf("rnd%0d", i));
            if ((m_halted && $urandom % 4 == 0) || $urandom % 300 == 0)
                do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
